// File: rtl/noc_input_buffer.sv
// rtl/noc_input_buffer.sv - per-port NoC router input FIFO with registered pop stage
// Optional handshake statistics counter is compiled in with `define BUF_STATS_EN.
module noc_input_buffer #(
    parameter int          DEPTH = 4,
    parameter int          PTR_W = 2,
    parameter logic [3:0]  ADDR  = 4'b0000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [31:0]      in_flit,
    output logic             in_ready,
    input  logic             out_ready,
    output logic             enable,
    output logic [31:0]      flit_out,
    output logic [PTR_W:0]   count
`ifdef BUF_STATS_EN
    ,
    output logic [15:0]      hs_seen
`endif
);

    localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

    logic [31:0]      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;

    // Both handshakes look only at registered count, so there is no bypass path.
    assign in_ready = (count != FULL);
    assign push     = in_valid && in_ready;
    assign pop      = out_ready && (count != '0);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_flit;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            enable   <= 1'b0;
            flit_out <= 32'h0;
        end else begin
            enable <= pop;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                flit_out <= mem[rd_ptr];
                rd_ptr   <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef BUF_STATS_EN
    logic hs_hit;

    assign hs_hit = push && (in_flit[31:30] == 2'b11) && (in_flit[25:22] == ADDR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_seen <= 16'h0;
        end else if (hs_hit && (hs_seen != 16'hFFFF)) begin
            hs_seen <= hs_seen + 16'h1;
        end
    end
`endif

endmodule

// File: tb/tb_noc_input_buffer.sv
// tb/tb_noc_input_buffer.sv - randomized self-checking bench for noc_input_buffer
module tb_noc_input_buffer;

    localparam int         DEPTH = 4;
    localparam int         PTR_W = 2;
    localparam logic [3:0] ADDR  = 4'b0001;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_flit;
    logic        in_ready;
    logic        out_ready;
    logic        enable;
    logic [31:0] flit_out;
    logic [2:0]  count;
`ifdef BUF_STATS_EN
    logic [15:0] hs_seen;
`endif

    noc_input_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W), .ADDR(ADDR)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_flit   (in_flit),
        .in_ready  (in_ready),
        .out_ready (out_ready),
        .enable    (enable),
        .flit_out  (flit_out),
        .count     (count)
`ifdef BUF_STATS_EN
        ,
        .hs_seen   (hs_seen)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;

    logic [31:0] model_q[$];
    logic        exp_en;
    logic [31:0] exp_fo;
    int          exp_hs;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        model_q.delete();
        exp_en = 1'b0;
        exp_fo = 32'h0;
        exp_hs = 0;
    endtask

    // One clock cycle: drive, check in_ready, advance model and DUT, check outputs.
    task automatic step(input logic v, input logic [31:0] f, input logic ordy);
        bit was_full;
        bit do_pop;
        in_valid  = v;
        in_flit   = f;
        out_ready = ordy;
        #1;
        was_full = (model_q.size() == DEPTH);
        check("in_ready", 32'(in_ready), 32'(!was_full));
        do_pop = ordy && (model_q.size() != 0);
        exp_en = do_pop;
        if (do_pop) exp_fo = model_q.pop_front();
        if (v && !was_full) begin
            model_q.push_back(f);
            if (f[31:30] == 2'b11 && f[25:22] == ADDR && exp_hs < 65535) exp_hs++;
        end
        @(posedge clk);
        #1;
        check("enable", 32'(enable), 32'(exp_en));
        check("flit_out", flit_out, exp_fo);
        check("count", 32'(count), 32'(model_q.size()));
`ifdef BUF_STATS_EN
        check("hs_seen", 32'(hs_seen), 32'(exp_hs));
`endif
    endtask

    task automatic async_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        model_reset();
        check("rst_count", 32'(count), 32'd0);
        check("rst_enable", 32'(enable), 32'd0);
        check("rst_flit_out", flit_out, 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef BUF_STATS_EN
        check("rst_hs_seen", 32'(hs_seen), 32'd0);
`endif
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] f;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_flit   = 32'h0;
        out_ready = 1'b0;
        model_reset();
        #12;
        check("reset_count", 32'(count), 32'd0);
        check("reset_enable", 32'(enable), 32'd0);
        check("reset_flit_out", flit_out, 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single flit latency: pop only after the cycle following the push.
        step(1'b1, 32'hC0400005, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b1);

        // Fill to full, then hold a fifth flit that must be refused.
        for (int i = 1; i <= 4; i++) step(1'b1, 32'(i), 1'b0);
        step(1'b1, 32'h5, 1'b0);
        step(1'b1, 32'h5, 1'b0);
        // Drain with the fifth flit still offered; it enters once in_ready rises.
        for (int i = 0; i < 6; i++) step(1'b1, 32'h5, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1);

        // Streaming push and pop across pointer wrap.
        for (int i = 0; i < 10; i++) step(1'b1, 32'hA0 + 32'(i), 1'b1);
        step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b1);

        // Reset mid-stream with three entries held.
        for (int i = 0; i < 3; i++) step(1'b1, 32'hB0 + 32'(i), 1'b0);
        check("pre_reset_count", 32'(count), 32'd3);
        async_reset();
        step(1'b1, 32'hD1, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b1);

        // Handshake statistics patterns (destination match and mismatch).
        step(1'b1, 32'hC0400000, 1'b0);
        step(1'b1, 32'hC0800000, 1'b0);
        step(1'b1, 32'h00400000, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1);

        // Randomized traffic with biased readiness to visit full and empty.
        for (int i = 0; i < 600; i++) begin
            f = $urandom;
            if ($urandom_range(0, 3) == 0) begin
                f[31:30] = 2'b11;
                f[25:22] = ADDR;
            end
            step(1'($urandom_range(0, 1)), f,
                 (i % 200 < 100) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));
            if (i == 300) async_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
